sequential_divider: RTL

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, fixed WIDTH+1 clock latency.
// Divide by zero falls out of the datapath as all-ones quotient and remainder = dividend.
module sequential_divider #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             quotientDone,
  output logic             divByZero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    step_t;
  logic [PW-1:0]    step_s;
  logic [PW-1:0]    step_p;
  logic [WIDTH-1:0] step_q;

  // One restoring step; subtraction always evaluated, sign of S selects the result.
  always_comb begin
    step_t = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    step_s = step_t - {1'b0, d_q};
    step_p = step_s[WIDTH] ? step_t : step_s;
    step_q = {q_q[WIDTH-2:0], ~step_s[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          p_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        // Last of WIDTH steps: publish the freshly computed bit along with the result.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = step_q;
          rem_d   = step_p[WIDTH-1:0];
          dbz_d   = (d_q == '0);
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
    end
  end

  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign quotientDone = done_q;
  assign divByZero    = dbz_q;
  assign busy         = busy_q;

endmodule
